// File: rtl/seven_segment_display_595_n.sv
// Multiplexed seven-segment driver for two daisy-chained 74HC595 shift
// registers. One 16-bit word {seg, sel} is shifted out MSB first per scan
// tick. Inputs are snapshotted at the start of each frame so a frame never
// mixes old and new values.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a scan tick; builds the next word on the tick
// SHIFT_LO | sclk low, dio presents the current bit
// SHIFT_HI | sclk high, the 595 captures dio on the rising edge
// LATCH    | data setup with sclk low, then rclk pulse transfers the word
module seven_segment_display_595_n #(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int SCAN_FREQ      = 1000,
  parameter int DIGITS         = 8,
  parameter int SCLK_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dps,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic                  dio,
  output logic                  sclk,
  output logic                  rclk,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int TICK = CLOCK_FREQ / SCAN_FREQ;
  localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int DW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [DW-1:0]       div_cnt, div_nx;
  logic                div_done;
  logic [3:0]          bit_idx, bit_nx;
  logic [15:0]         word, word_nx;
  logic [2:0]          idx, idx_nx;
  logic                lat_ph, lat_nx;
  logic                dio_nx, sclk_nx, rclk_nx, busy_nx, fd_nx;

  logic [4*DIGITS-1:0] sh_dig;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_bl;
  logic                sh_lz;

  logic [4*DIGITS-1:0] src_dig;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_bl;
  logic                src_lz;

  logic [31:0]         dig8;
  logic [7:0]          dp8, bl8, supp8;
  logic [7:0]          seg_ah, sel_ah, seg_out, sel_out;
  logic [15:0]         built;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // free-running scan tick counter; the wrap cycle is the tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick     = (tick_cnt == TICK_LAST);
  assign div_done = (div_cnt == DIV_LAST);

  // capture the frame's inputs when the idx0 word is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_bl  <= '0;
      sh_lz  <= 1'b0;
    end else if (state == IDLE && tick && idx == 3'd0) begin
      sh_dig <= digits;
      sh_dp  <= dps;
      sh_bl  <= blank;
      sh_lz  <= lz_en;
    end
  end

  // the idx0 word is built from live inputs, the same values being snapshotted
  always_comb begin
    src_dig = sh_dig;
    src_dp  = sh_dp;
    src_bl  = sh_bl;
    src_lz  = sh_lz;
    if (idx == 3'd0) begin
      src_dig = digits;
      src_dp  = dps;
      src_bl  = blank;
      src_lz  = lz_en;
    end
  end

  // leading-zero suppression scanned from the top digit downwards;
  // blanked digits are transparent to the scan
  always_comb begin
    logic       lead;
    logic       zero_nodp;
    logic [3:0] nib;
    lead      = 1'b1;
    zero_nodp = 1'b0;
    nib       = 4'h0;
    dig8      = '0;
    dp8       = '0;
    bl8       = '0;
    supp8     = '0;
    dig8[4*DIGITS-1:0] = src_dig;
    dp8[DIGITS-1:0]    = src_dp;
    bl8[DIGITS-1:0]    = src_bl;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nib       = src_dig[4*i +: 4];
      zero_nodp = (nib == 4'h0) && !src_dp[i];
      supp8[i]  = src_lz && lead && zero_nodp;
      lead      = lead && (src_bl[i] || zero_nodp);
    end
  end

  // word for the current digit; polarity applied last
  always_comb begin
    seg_ah = {dp8[idx], hex7(dig8[{idx, 2'b00} +: 4])};
    if (bl8[idx] || supp8[idx]) begin
      seg_ah = 8'h00;
    end
    sel_ah  = 8'b0000_0001 << idx;
    seg_out = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
    sel_out = SEL_ACTIVE_LOW ? ~sel_ah : sel_ah;
    built   = {seg_out, sel_out};
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_idx    <= 4'd0;
      word       <= 16'h0000;
      idx        <= 3'd0;
      lat_ph     <= 1'b0;
      dio        <= 1'b0;
      sclk       <= 1'b0;
      rclk       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      div_cnt    <= div_nx;
      bit_idx    <= bit_nx;
      word       <= word_nx;
      idx        <= idx_nx;
      lat_ph     <= lat_nx;
      dio        <= dio_nx;
      sclk       <= sclk_nx;
      rclk       <= rclk_nx;
      busy       <= busy_nx;
      frame_done <= fd_nx;
    end
  end

  // FSM next state; ticks outside IDLE are dropped
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_idx;
    word_nx  = word;
    idx_nx   = idx;
    lat_nx   = lat_ph;
    dio_nx   = dio;
    sclk_nx  = sclk;
    rclk_nx  = rclk;
    busy_nx  = busy;
    fd_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          word_nx  = built;
          dio_nx   = built[15];
          sclk_nx  = 1'b0;
          busy_nx  = 1'b1;
          div_nx   = '0;
          bit_nx   = 4'd15;
          state_nx = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          div_nx   = '0;
          sclk_nx  = 1'b1;
          state_nx = SHIFT_HI;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          div_nx  = '0;
          sclk_nx = 1'b0;
          if (bit_idx == 4'd0) begin
            lat_nx   = 1'b0;
            state_nx = LATCH;
          end else begin
            bit_nx   = bit_idx - 4'd1;
            dio_nx   = word[bit_idx - 4'd1];
            state_nx = SHIFT_LO;
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        // phase 0 leaves sclk low for a half period before rclk rises
        if (div_done) begin
          div_nx = '0;
          if (!lat_ph) begin
            lat_nx  = 1'b1;
            rclk_nx = 1'b1;
          end else begin
            lat_nx   = 1'b0;
            rclk_nx  = 1'b0;
            busy_nx  = 1'b0;
            fd_nx    = (idx == IDX_LAST);
            idx_nx   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            state_nx = IDLE;
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: doc/seven_segment_display_595_n.md
Name: seven_segment_display_595_n

Overview:
- Parametrised successor to the fixed 8-digit serial seven-segment driver.
- Drives N multiplexed digits through two daisy-chained 74HC595 shift registers using a serial data line, a shift clock and a latch clock.
- Adds the following over the previous generation:
  - configurable digit count, polarity and shift rate;
  - hex decode;
  - per-digit blanking;
  - leading-zero suppression;
  - tear-free frame snapshot, plus busy and frame_done status.
- Sits between the frequency-counter BCD output stage and the board display pins.

Parameters:
- CLOCK_FREQ, 50000000: system clock frequency in Hz.
- SCAN_FREQ, 1000: digit-step rate in Hz. One digit is shifted per tick; TICK = CLOCK_FREQ/SCAN_FREQ clk cycles.
- DIGITS, 8: number of digits, legal range 1..8.
- SCLK_DIV, 4: sclk half-period in clk cycles, >=1.
- SEG_ACTIVE_LOW, 1: 1 inverts the segment byte (common anode).
- SEL_ACTIVE_LOW, 1: 1 inverts the select byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- digits  in  4*DIGITS  digit i = digits[4i+3:4i], hex value 0-F; digit 0 is the rightmost.
- dps  in  DIGITS  decimal point per digit, 1 = lit.
- blank  in  DIGITS  1 = digit fully dark.
- lz_en  in  1  leading-zero suppression enable.
- dio  out  1  serial data to the 595 chain.
- sclk  out  1  shift clock; data is captured on the rising edge.
- rclk  out  1  storage latch clock.
- busy  out  1  high while a 16-bit word is being shifted or latched.
- frame_done  out  1  one-cycle pulse after digit DIGITS-1 is latched.

Behaviour:
- **Reset** (rst low, asynchronous): dio=0, sclk=0, rclk=0, busy=0, frame_done=0.
  - Tick counter, digit index and FSM are cleared to their initial state; shadow registers are cleared.
  - Reset mid-shift aborts immediately; rclk never pulses for a partial word.
- **Tick counter**: counts 0..TICK-1 and wraps. The wrap cycle is a tick; the first tick occurs TICK cycles after rst rises.
- **Snapshot**: on a tick with idx==0, digits, dps, blank and lz_en are copied into shadow registers. Those shadow values are used for the whole frame (idx 0..DIGITS-1), so input changes mid-frame never tear.
- **Word format**: 16 bits, MSB first, {seg[7:0], sel[7:0]}.
  - seg bits: bit0=a … bit6=g, bit7=dp.
  - sel: one-hot at bit idx; bits >= DIGITS are inactive.
  - Polarity is applied last: seg is inverted if SEG_ACTIVE_LOW; sel is inverted if SEL_ACTIVE_LOW.
- **Decode** (active-high, before inversion): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- **Blanking**: a blanked digit has seg=00 and its dp is forced off.
- **Leading-zero suppression** (lz_en=1): digit i>0 is blanked when:
  - its value is 0, and its dp is 0, and
  - every digit above i (up to DIGITS-1) is also 0 with dp 0 or blanked.
  - Digit 0 is never suppressed.
- **FSM**:
  - IDLE: on tick, build the word, assert busy, go to SHIFT_LO.
  - SHIFT_LO: sclk=0; dio is set to the current bit; hold SCLK_DIV cycles, then go to SHIFT_HI.
  - SHIFT_HI: sclk=1; hold SCLK_DIV cycles. After bit 15 go to LATCH, otherwise advance to the next bit and return to SHIFT_LO.
  - LATCH: sclk=0 and rclk=1 for SCLK_DIV cycles. Then rclk=0, busy=0, and idx increments, wrapping DIGITS-1 -> 0. frame_done pulses on the cycle the wrap occurs. Return to IDLE.
- **Word timing**: one word takes 34*SCLK_DIV cycles. A tick arriving while busy is dropped; idx does not advance and the frame stretches. Integrators must keep 34*SCLK_DIV < TICK.
- **DIGITS=1**: idx stays 0, a snapshot is taken every tick, and frame_done pulses every word.
- dio holds its last value outside SHIFT states; sclk and rclk are never high simultaneously.

Test Plan:
- Reset/tick: CLOCK_FREQ=1000, SCAN_FREQ=10 (TICK=100), SCLK_DIV=2, DIGITS=4, hold rst low 50 cycles.
  - Required: all outputs 0 during reset.
  - Required: first sclk rise 102 cycles after rst high.
  - Required: busy high for 68 cycles; exactly 16 sclk rises, then one 2-cycle rclk pulse.
- Word content: digits=16'h4321, dps=4'b0010, SEG/SEL_ACTIVE_LOW=1.
  - Required words, sampled on sclk rises: idx0 = F9FE, idx1 = 24FD (dp on → seg DB → inverted 24), idx2 = B0FB, idx3 = 99F7.
  - Required: frame_done pulses after idx3.
- Active-high polarity: both ACTIVE_LOW=0, digits=16'h00A8.
  - Required: idx0 word = 7F01, idx1 word = 7702.
- Leading zeros: lz_en=1, digits=16'h0050, dps=0, blank=0.
  - Required: idx3 and idx2 seg=FF (dark), idx1 seg=92 ('5'), idx0 seg=C0 ('0').
  - Repeat with dps=4'b0100: idx2 shows '0' with dp, seg=40.
- Tear-free: change digits during idx1 of a frame.
  - Required: the remaining words of that frame use the old values; the new values appear from the next idx0.
  - Also: assert blank[0] → idx0 seg=FF.
- Reset mid-word: drop rst during bit 7 of a word.
  - Required: sclk, rclk, dio, busy go to 0 immediately with no rclk pulse.
  - After release, the next word is idx0 at TICK+2 cycles.
